fifo_wr_arbiter: RTL

//   Shares one write port of the team's synchronous FIFO (wr/w_data/full) among N requesters.

---
 rtl/fifo_wr_arb_pkg.sv | 6 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared state type and statistics constants for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;
   typedef enum logic {IDLE, BURST} state_t;
   localparam int STAT_W = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; the first requester at or after rr_ptr (mod N) wins.
module rr_pick #(
   parameter int N = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] rr_ptr,
   output logic           any,
   output logic [IDW-1:0] winner
);
   // Scan from farthest to nearest so the requester closest to rr_ptr is written last.
   always_comb begin
      any = 1'b0;
      winner = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(rr_ptr) + k) % N]) begin
            any = 1'b1;
            winner = IDW'((int'(rr_ptr) + k) % N);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-capped sharing of one FIFO write port among N requesters.
// Defining FIFO_WR_ARB_STATS_EN adds per-requester saturating accepted-beat counters (grant_cnt).
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int B = 8,
   parameter int MAX_BURST = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N*B-1:0]   req_data,
   output logic [N-1:0]     ack,
   output logic [N-1:0]     grant,
   output logic [IDW-1:0]   owner,
   output logic             busy,
   output logic             fifo_wr,
   output logic [B-1:0]     fifo_w_data,
   input  logic             fifo_full
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [N*STAT_W-1:0] grant_cnt
`endif
);
   localparam int CW = $clog2(MAX_BURST + 1);
   state_t         state, state_nx;
   logic [IDW-1:0] rr_ptr, rr_ptr_nx, owner_nx, winner;
   logic [N-1:0]   grant_nx;
   logic [CW-1:0]  beat_cnt, beat_cnt_nx;
   logic           any, last;
   rr_pick #(.N(N)) u_pick (
      .req(req),
      .rr_ptr(rr_ptr),
      .any(any),
      .winner(winner)
   );
   assign busy = state == BURST;
   assign fifo_wr = busy & req[owner] & ~fifo_full;
   assign fifo_w_data = busy ? req_data[owner*B +: B] : '0;
   assign ack = grant & {N{fifo_wr}};
   // Burst ends when the owner withdraws or its final permitted beat is accepted.
   assign last = ~req[owner] | (fifo_wr & (beat_cnt == CW'(MAX_BURST - 1)));
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      grant_nx = grant;
      beat_cnt_nx = beat_cnt;
      rr_ptr_nx = rr_ptr;
      if (!busy) begin
         if (any) begin
            state_nx = BURST;
            owner_nx = winner;
            grant_nx = {{(N-1){1'b0}}, 1'b1} << winner;
            beat_cnt_nx = '0;
         end
      end else if (last) begin
         state_nx = IDLE;
         grant_nx = '0;
         rr_ptr_nx = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
      end else if (fifo_wr) begin
         beat_cnt_nx = beat_cnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= '0;
         grant <= '0;
         beat_cnt <= '0;
         rr_ptr <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         grant <= grant_nx;
         beat_cnt <= beat_cnt_nx;
         rr_ptr <= rr_ptr_nx;
      end
   end
`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (ack[k] && grant_cnt[k*STAT_W +: STAT_W] != STAT_MAX)
               grant_cnt[k*STAT_W +: STAT_W] <= grant_cnt[k*STAT_W +: STAT_W] + 1'b1;
         end
      end
   end
`endif
endmodule
